// File: rtl/kmeans_accumulator_k3_d5_if.sv
// Handshake/bus bundle for kmeans_accumulator_k3_d5.
//   master : upstream sample source + downstream record sink (testbench side)
//   slave  : the accumulator itself
// Signals: start pulse, sample stream (in_valid/in_last/in_ready,
// input_data0..4, selected_centroid), drain stream (out_valid/out_ready,
// out_centroid_id, out_sum0..4, out_count) and the done pulse.
interface kmeans_accumulator_k3_d5_if #(
  parameter int unsigned input_data_width  = 16,
  parameter int unsigned centroid_id_width = 2,
  parameter int unsigned acc_width         = 32,
  parameter int unsigned count_width       = 16
) ();
  logic                         start;
  logic                         in_valid;
  logic                         in_last;
  logic                         in_ready;
  logic [input_data_width-1:0]  input_data0;
  logic [input_data_width-1:0]  input_data1;
  logic [input_data_width-1:0]  input_data2;
  logic [input_data_width-1:0]  input_data3;
  logic [input_data_width-1:0]  input_data4;
  logic [centroid_id_width-1:0] selected_centroid;
  logic                         out_valid;
  logic                         out_ready;
  logic [centroid_id_width-1:0] out_centroid_id;
  logic [acc_width-1:0]         out_sum0;
  logic [acc_width-1:0]         out_sum1;
  logic [acc_width-1:0]         out_sum2;
  logic [acc_width-1:0]         out_sum3;
  logic [acc_width-1:0]         out_sum4;
  logic [count_width-1:0]       out_count;
  logic                         done;

  modport master (
    output start, in_valid, in_last, selected_centroid,
    output input_data0, input_data1, input_data2, input_data3, input_data4,
    output out_ready,
    input  in_ready, out_valid, out_centroid_id, out_count, done,
    input  out_sum0, out_sum1, out_sum2, out_sum3, out_sum4
  );

  modport slave (
    input  start, in_valid, in_last, selected_centroid,
    input  input_data0, input_data1, input_data2, input_data3, input_data4,
    input  out_ready,
    output in_ready, out_valid, out_centroid_id, out_count, done,
    output out_sum0, out_sum1, out_sum2, out_sum3, out_sum4
  );
endinterface

// File: rtl/kmeans_accumulator_k3_d5.sv
// Per-epoch centroid accumulator, 3 centroids x 5 dimensions.
// Accumulates per-centroid coordinate sums and sample counts for one epoch,
// then drains one record per centroid (ids 0,1,2) with valid/ready.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : kmeans_accumulator_k3_d5_if.slave (sample in, record out, start, done)
// Build option: KMEANS_ACC_SAT_EN makes sums/counts saturate instead of wrap.
module kmeans_accumulator_k3_d5 #(
  parameter int unsigned input_data_width  = 16,
  parameter int unsigned centroid_id_width = 2,
  parameter int unsigned acc_width         = 32,
  parameter int unsigned count_width       = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  kmeans_accumulator_k3_d5_if.slave bus
);

  localparam int NK = 3;
  localparam int ND = 5;
`ifdef KMEANS_ACC_SAT_EN
  localparam int unsigned AW1 = acc_width + 1;
  localparam int unsigned CW1 = count_width + 1;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN} state_e;

  state_e                       state_q, state_d;
  logic [1:0]                   idx_q, idx_d;
  logic [acc_width-1:0]         sum_q [NK][ND];
  logic [acc_width-1:0]         sum_d [NK][ND];
  logic [count_width-1:0]       cnt_q [NK];
  logic [count_width-1:0]       cnt_d [NK];

  logic                         in_ready_q, in_ready_d;
  logic                         out_valid_q, out_valid_d;
  logic                         done_q, done_d;
  logic [centroid_id_width-1:0] out_id_q, out_id_d;
  logic [acc_width-1:0]         out_sum_q [ND];
  logic [acc_width-1:0]         out_sum_d [ND];
  logic [count_width-1:0]       out_cnt_q, out_cnt_d;

  logic                         clear_c;
  logic                         accum_c;
  logic                         accept_c;
  logic [input_data_width-1:0]  data_c [ND];

  function automatic logic [acc_width-1:0] add_sum(input logic [acc_width-1:0]        a,
                                                    input logic [input_data_width-1:0] b);
`ifdef KMEANS_ACC_SAT_EN
    logic [AW1-1:0] s;
    s = AW1'(a) + AW1'(b);
    return s[AW1-1] ? '1 : s[acc_width-1:0];
`else
    return a + acc_width'(b);
`endif
  endfunction

  function automatic logic [count_width-1:0] inc_cnt(input logic [count_width-1:0] a);
`ifdef KMEANS_ACC_SAT_EN
    logic [CW1-1:0] s;
    s = CW1'(a) + CW1'(1);
    return s[CW1-1] ? '1 : s[count_width-1:0];
`else
    return a + count_width'(1);
`endif
  endfunction

  // Qualified events; start is only honoured outside DRAIN and beats a same-cycle sample
  always_comb begin
    data_c[0] = bus.input_data0;
    data_c[1] = bus.input_data1;
    data_c[2] = bus.input_data2;
    data_c[3] = bus.input_data3;
    data_c[4] = bus.input_data4;
    clear_c   = bus.start && (state_q != S_DRAIN);
    accum_c   = (state_q == S_ACCUM) && bus.in_valid && !bus.start;
    accept_c  = (state_q == S_DRAIN) && out_valid_q && bus.out_ready;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_ACCUM;
      end
      S_ACCUM: begin
        if (!bus.start && bus.in_valid && bus.in_last) begin
          state_d = S_DRAIN;
          idx_d   = 2'd0;
        end
      end
      S_DRAIN: begin
        if (accept_c) begin
          if (idx_q == 2'd2) state_d = S_IDLE;
          else               idx_d   = idx_q + 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Accumulator next values; ids outside 0..2 match no centroid and are dropped
  always_comb begin
    for (int k = 0; k < NK; k++) begin
      cnt_d[k] = cnt_q[k];
      for (int d = 0; d < ND; d++) sum_d[k][d] = sum_q[k][d];
      if (clear_c) begin
        cnt_d[k] = '0;
        for (int d = 0; d < ND; d++) sum_d[k][d] = '0;
      end else if (accum_c && (bus.selected_centroid == centroid_id_width'(k))) begin
        cnt_d[k] = inc_cnt(cnt_q[k]);
        for (int d = 0; d < ND; d++) sum_d[k][d] = add_sum(sum_q[k][d], data_c[d]);
      end
    end
  end

  // Output next values; the record tracks sum_d so the last sample lands in record 0
  always_comb begin
    in_ready_d  = (state_d == S_ACCUM);
    out_valid_d = (state_d == S_DRAIN);
    done_d      = accept_c && (idx_q == 2'd2);
    out_id_d    = out_id_q;
    out_cnt_d   = out_cnt_q;
    for (int d = 0; d < ND; d++) out_sum_d[d] = out_sum_q[d];
    if (state_d == S_DRAIN) begin
      out_id_d = centroid_id_width'(idx_d);
      for (int k = 0; k < NK; k++) begin
        if (idx_d == 2'(k)) begin
          out_cnt_d = cnt_d[k];
          for (int d = 0; d < ND; d++) out_sum_d[d] = sum_d[k][d];
        end
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NK; k++) begin
        cnt_q[k] <= '0;
        for (int d = 0; d < ND; d++) sum_q[k][d] <= '0;
      end
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      out_id_q    <= '0;
      out_cnt_q   <= '0;
      for (int d = 0; d < ND; d++) out_sum_q[d] <= '0;
    end else begin
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      out_id_q    <= out_id_d;
      out_cnt_q   <= out_cnt_d;
      out_sum_q   <= out_sum_d;
    end
  end

  assign bus.in_ready        = in_ready_q;
  assign bus.out_valid       = out_valid_q;
  assign bus.done            = done_q;
  assign bus.out_centroid_id = out_id_q;
  assign bus.out_count       = out_cnt_q;
  assign bus.out_sum0        = out_sum_q[0];
  assign bus.out_sum1        = out_sum_q[1];
  assign bus.out_sum2        = out_sum_q[2];
  assign bus.out_sum3        = out_sum_q[3];
  assign bus.out_sum4        = out_sum_q[4];

endmodule
